// File: rtl/dma_streamer.sv
// dma_streamer: walks one descriptor at a time and breaks it into AXI-style
// bursts. INCR bursts are clipped to MAX_BEATS and never cross a 4 KB page.
// FIXED bursts are clipped to 16 beats. Assumes ADDR_W >= 12.
module dma_streamer #(
    parameter int NUM_DESC  = 2,
    parameter int ADDR_W    = 32,
    parameter int BUS_BYTES = 8,
    parameter int MAX_BEATS = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                str_valid_i,
    input  logic [$clog2(NUM_DESC)-1:0]         str_idx_i,
    input  logic [NUM_DESC-1:0][ADDR_W-1:0]     desc_addr_i,
    input  logic [NUM_DESC-1:0][31:0]           desc_bytes_i,
    input  logic [NUM_DESC-1:0]                 desc_fixed_i,
    output logic                                req_valid_o,
    input  logic                                req_ready_i,
    output logic [ADDR_W-1:0]                   req_addr_o,
    output logic [7:0]                          req_len_o,
    output logic                                req_fixed_o,
    output logic                                done_o,
    output logic                                busy_o
);

    localparam int SH = $clog2(BUS_BYTES);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rem_q;
    logic [8:0]        beats_q;
    logic              fixed_q;

    logic              load;
    logic              calc;
    logic              hs;
    logic [31:0]       rem_after;

    // Beats needed to move a byte count, rounded up to whole bus words.
    function automatic logic [31:0] ceil_beats(input logic [31:0] bytes);
        logic [31:0] mask;
        mask = 32'(BUS_BYTES - 1);
        ceil_beats = (bytes >> SH) + (((bytes & mask) != 32'd0) ? 32'd1 : 32'd0);
    endfunction

    // Size of the next burst. Unaligned low address bits are ignored when
    // measuring the distance to the next 4 KB page.
    function automatic logic [8:0] burst_beats(input logic [ADDR_W-1:0] a,
                                               input logic [31:0]       rem,
                                               input logic              fx);
        logic [12:0] off;
        logic [12:0] room;
        logic [31:0] lim;
        off  = {1'b0, a[11:0] & ~12'(BUS_BYTES - 1)};
        room = (13'd4096 - off) >> SH;
        if (fx)
            lim = 32'd16;
        else if (32'(room) < 32'(MAX_BEATS))
            lim = 32'(room);
        else
            lim = 32'(MAX_BEATS);
        burst_beats = (rem < lim) ? rem[8:0] : lim[8:0];
    endfunction

    assign rem_after = rem_q - 32'(beats_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode and control outputs; a falling str_valid_i aborts.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        calc        = 1'b0;
        hs          = 1'b0;
        req_valid_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (str_valid_i) begin
                    load    = 1'b1;
                    state_d = (desc_bytes_i[str_idx_i] == 32'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!str_valid_i) begin
                    state_d = IDLE;
                end else begin
                    calc    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_valid_o = 1'b1;
                if (req_ready_i) begin
                    hs = 1'b1;
                    if (!str_valid_i)
                        state_d = IDLE;
                    else if (rem_after == 32'd0)
                        state_d = DONE;
                    else
                        state_d = CALC;
                end else if (!str_valid_i) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Descriptor working registers: load, size the burst, retire on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            fixed_q <= 1'b0;
        end else if (load) begin
            addr_q  <= desc_addr_i[str_idx_i];
            rem_q   <= ceil_beats(desc_bytes_i[str_idx_i]);
            fixed_q <= desc_fixed_i[str_idx_i];
            beats_q <= '0;
        end else if (calc) begin
            beats_q <= burst_beats(addr_q, rem_q, fixed_q);
        end else if (hs) begin
            rem_q <= rem_after;
            if (!fixed_q)
                addr_q <= addr_q + (ADDR_W'(beats_q) << SH);
        end
    end

    assign req_addr_o  = addr_q;
    assign req_len_o   = (beats_q == 9'd0) ? 8'd0 : 8'(beats_q - 9'd1);
    assign req_fixed_o = fixed_q;

endmodule

// File: tb/tb_dma_streamer.sv
// Bench for dma_streamer: directed descriptor table, hand-written corner
// sequences, and randomized descriptors checked against a burst-list model.
module tb_dma_streamer;

    localparam int BB = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             str_valid;
    logic [0:0]       str_idx;
    logic [1:0][31:0] desc_addr;
    logic [1:0][31:0] desc_bytes;
    logic [1:0]       desc_fixed;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [7:0]       req_len;
    logic             req_fixed;
    logic             done;
    logic             busy;

    int checks = 0;
    int passed = 0;

    logic [31:0] got_addr[$];
    logic [7:0]  got_len[$];
    logic        got_fix[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    int          last_hs_cyc;
    int          done_cyc;
    bit          got_done;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] bytes;
        logic        fixed;
        int          n;
        logic [31:0] ea[4];
        logic [7:0]  el[4];
    } vec_t;

    vec_t vecs[5];

    dma_streamer #(.NUM_DESC(2), .ADDR_W(32), .BUS_BYTES(BB), .MAX_BEATS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .str_valid_i  (str_valid),
        .str_idx_i    (str_idx),
        .desc_addr_i  (desc_addr),
        .desc_bytes_i (desc_bytes),
        .desc_fixed_i (desc_fixed),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .req_addr_o   (req_addr),
        .req_len_o    (req_len),
        .req_fixed_o  (req_fixed),
        .done_o       (done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Burst list derived straight from the page/size rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic f);
        longint unsigned rem, room, n;
        logic [31:0] cur;
        exp_addr.delete();
        exp_len.delete();
        rem = (longint'(b) + BB - 1) / BB;
        cur = a;
        while (rem > 0) begin
            if (f) begin
                n = (rem < 16) ? rem : 16;
            end else begin
                room = (4096 - ((longint'(cur) % 4096) / BB) * BB) / BB;
                n = rem;
                if (n > 256) n = 256;
                if (n > room) n = room;
            end
            exp_addr.push_back(cur);
            exp_len.push_back(8'(n - 1));
            rem = rem - n;
            if (!f) cur = cur + 32'(n * BB);
        end
    endtask

    task automatic start(input int slot, input logic [31:0] a, input logic [31:0] b, input logic f);
        @(negedge clk);
        str_idx            = slot[0:0];
        desc_addr[slot]    = a;
        desc_bytes[slot]   = b;
        desc_fixed[slot]   = f;
        str_valid          = 1'b1;
        req_ready          = 1'b0;
    endtask

    // Runs one descriptor to completion, logging every handshake.
    task automatic run_desc(input int slot, input logic [31:0] a, input logic [31:0] b,
                            input logic f, input int ready_pct, input bit scramble);
        logic [31:0] pa;
        logic [7:0]  pl;
        logic        pf;
        bit          pend;
        got_addr.delete();
        got_len.delete();
        got_fix.delete();
        got_done    = 0;
        last_hs_cyc = -100;
        done_cyc    = 0;
        pend        = 0;
        pa = '0; pl = '0; pf = 1'b0;
        start(slot, a, b, f);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (scramble) begin
                desc_addr  = {$urandom, $urandom};
                desc_bytes = {$urandom, $urandom};
                desc_fixed = 2'($urandom);
                str_idx    = 1'($urandom);
            end
            if (done) begin
                got_done  = 1;
                done_cyc  = cyc;
                str_valid = 1'b0;
                req_ready = 1'b0;
                break;
            end
            if (req_valid && pend) begin
                check("stall_addr", req_addr, pa);
                check("stall_len", req_len, pl);
                check("stall_fixed", req_fixed, pf);
            end
            req_ready = ($urandom_range(99) < ready_pct);
            if (req_valid) begin
                if (req_ready) begin
                    got_addr.push_back(req_addr);
                    got_len.push_back(req_len);
                    got_fix.push_back(req_fixed);
                    last_hs_cyc = cyc;
                    pend = 0;
                end else begin
                    pa = req_addr; pl = req_len; pf = req_fixed;
                    pend = 1;
                end
            end else begin
                pend = 0;
            end
        end
        if (!got_done) begin
            check("timeout_done", 0, 1);
            str_valid = 1'b0;
            req_ready = 1'b0;
        end
        @(negedge clk);
        check("done_one_cycle", {done, busy}, 2'b00);
    endtask

    initial begin
        bit          seen;
        logic [31:0] ra, rb;
        logic        rf;
        int          sl;

        vecs[0].addr = 32'h1000; vecs[0].bytes = 64;   vecs[0].fixed = 0; vecs[0].n = 1;
        vecs[0].ea[0] = 32'h1000; vecs[0].el[0] = 8'd7;
        vecs[1].addr = 32'h0FF0; vecs[1].bytes = 64;   vecs[1].fixed = 0; vecs[1].n = 2;
        vecs[1].ea[0] = 32'h0FF0; vecs[1].el[0] = 8'd1;
        vecs[1].ea[1] = 32'h1000; vecs[1].el[1] = 8'd5;
        vecs[2].addr = 32'h0;    vecs[2].bytes = 4096; vecs[2].fixed = 0; vecs[2].n = 2;
        vecs[2].ea[0] = 32'h0;    vecs[2].el[0] = 8'd255;
        vecs[2].ea[1] = 32'h800;  vecs[2].el[1] = 8'd255;
        vecs[3].addr = 32'h40;   vecs[3].bytes = 200;  vecs[3].fixed = 1; vecs[3].n = 2;
        vecs[3].ea[0] = 32'h40;   vecs[3].el[0] = 8'd15;
        vecs[3].ea[1] = 32'h40;   vecs[3].el[1] = 8'd8;
        vecs[4].addr = 32'h2000; vecs[4].bytes = 0;    vecs[4].fixed = 0; vecs[4].n = 0;

        rst        = 1'b1;
        str_valid  = 1'b0;
        str_idx    = '0;
        desc_addr  = '0;
        desc_bytes = '0;
        desc_fixed = '0;
        req_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {req_valid, done, busy}, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {req_valid, done, busy}, 3'b000);

        // Directed descriptor table, ready tied high.
        for (int i = 0; i < 5; i++) begin
            run_desc(i % 2, vecs[i].addr, vecs[i].bytes, vecs[i].fixed, 100, 0);
            check($sformatf("vec%0d_done", i), got_done, 1);
            check($sformatf("vec%0d_count", i), got_addr.size(), vecs[i].n);
            for (int j = 0; j < vecs[i].n && j < got_addr.size(); j++) begin
                check($sformatf("vec%0d_addr%0d", i, j), got_addr[j], vecs[i].ea[j]);
                check($sformatf("vec%0d_len%0d", i, j), got_len[j], vecs[i].el[j]);
                check($sformatf("vec%0d_fix%0d", i, j), got_fix[j], vecs[i].fixed);
            end
            if (vecs[i].n > 0)
                check($sformatf("vec%0d_done_lat", i), done_cyc - last_hs_cyc, 1);
        end

        // Stall for 5 cycles with descriptor inputs changing underneath.
        start(0, 32'h1000, 64, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("stall_first_valid", {req_valid, req_addr, req_len, req_fixed}, {1'b1, 32'h1000, 8'd7, 1'b0});
        desc_addr[0]  = 32'h5550;
        desc_bytes[0] = 32'd8;
        desc_fixed[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", k), {req_valid, req_addr, req_len, req_fixed},
                  {1'b1, 32'h1000, 8'd7, 1'b0});
        end
        req_ready = 1'b1;
        @(negedge clk);
        check("stall_done", done, 1'b1);
        str_valid = 1'b0;
        req_ready = 1'b0;
        @(negedge clk);

        // Abort in ISSUE (str_valid drops in cycle 3).
        start(1, 32'h3000, 128, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("abort_issue_valid", req_valid, 1'b1);
        str_valid = 1'b0;
        @(negedge clk);
        check("abort_issue_idle", {req_valid, busy}, 2'b00);
        seen = 0;
        repeat (4) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        check("abort_issue_nodone", seen, 1'b0);

        // Abort in CALC.
        start(0, 32'h3000, 128, 1'b0);
        @(negedge clk);
        check("abort_calc_busy", {busy, req_valid}, 2'b10);
        str_valid = 1'b0;
        @(negedge clk);
        check("abort_calc_idle", {busy, req_valid, done}, 3'b000);

        // Handshake on the same cycle str_valid falls: completes, no done.
        start(0, 32'h1000, 64, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("hs_fall_valid", req_valid, 1'b1);
        req_ready = 1'b1;
        str_valid = 1'b0;
        @(negedge clk);
        req_ready = 1'b0;
        check("hs_fall_idle", {busy, done, req_valid}, 3'b000);
        @(negedge clk);
        check("hs_fall_nodone", done, 1'b0);

        // Reset mid-ISSUE.
        start(1, 32'h40, 200, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_valid", {req_valid, req_addr, req_len, req_fixed}, {1'b1, 32'h40, 8'd15, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {req_valid, done, busy, req_addr, req_len, req_fixed}, 44'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_first_cycle", {req_valid, done}, 2'b00);
        str_valid = 1'b0;
        @(negedge clk);

        // Random descriptors, random ready, inputs scrambled while busy.
        for (int it = 0; it < 30; it++) begin
            ra = $urandom;
            if ($urandom_range(1) == 1) ra[11:0] = 12'(4096 - $urandom_range(1, 300));
            rb = $urandom_range(0, 6000);
            rf = 1'($urandom);
            sl = $urandom_range(1);
            model(ra, rb, rf);
            run_desc(sl, ra, rb, rf, 60, 1);
            check($sformatf("rnd%0d_done", it), got_done, 1);
            check($sformatf("rnd%0d_count", it), got_addr.size(), exp_addr.size());
            for (int j = 0; j < exp_addr.size() && j < got_addr.size(); j++) begin
                check($sformatf("rnd%0d_addr%0d", it, j), got_addr[j], exp_addr[j]);
                check($sformatf("rnd%0d_len%0d", it, j), got_len[j], exp_len[j]);
                check($sformatf("rnd%0d_fix%0d", it, j), got_fix[j], rf);
                if (!rf)
                    check($sformatf("rnd%0d_page%0d", it, j),
                          ((got_addr[j] % 4096) / BB) * BB + (got_len[j] + 1) * BB <= 4096, 1);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dma_streamer.md
DMA_STREAMER -- requirements
Module: dma_streamer

Interface
REQ-001 SHALL have parameter NUM_DESC, default 2: number of descriptor slots.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter BUS_BYTES, default 8: data bus width in bytes, a power of two.
REQ-004 SHALL have parameter MAX_BEATS, default 256: INCR burst beat limit, at most 256.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port str_valid_i, input, 1 bit: descriptor transfer requested.
REQ-008 SHALL have port str_idx_i, input, $clog2(NUM_DESC) bits: descriptor index.
REQ-009 SHALL have port desc_addr_i, input, NUM_DESC x ADDR_W bits: per-descriptor start address.
REQ-010 SHALL have port desc_bytes_i, input, NUM_DESC x 32 bits: per-descriptor byte count.
REQ-011 SHALL have port desc_fixed_i, input, NUM_DESC x 1 bit: 1 = FIXED address mode, 0 = INCR.
REQ-012 SHALL have port req_valid_o, input/output as output, 1 bit: burst request valid.
REQ-013 SHALL have port req_ready_i, input, 1 bit: burst request accepted.
REQ-014 SHALL have port req_addr_o, output, ADDR_W bits: burst start address.
REQ-015 SHALL have port req_len_o, output, 8 bits: beats minus 1, AXI encoding.
REQ-016 SHALL have port req_fixed_o, output, 1 bit: burst type FIXED.
REQ-017 SHALL have port done_o, output, 1 bit: one-cycle descriptor-complete pulse.
REQ-018 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, CALC, ISSUE and DONE.
REQ-020 In IDLE with str_valid_i=1, SHALL latch str_idx_i and that slot's address, byte count and mode, compute remaining beats = ceil(bytes/BUS_BYTES), and go to CALC.
REQ-021 If the latched byte count is 0, SHALL go from IDLE straight to DONE without issuing a request.
REQ-022 In CALC (one cycle), SHALL register the burst beats as: for INCR, min(remaining, MAX_BEATS, beats up to the next 4 KB boundary); for FIXED, min(remaining, 16); SHALL then go to ISSUE.
REQ-023 In ISSUE, SHALL assert req_valid_o and hold addr, len and fixed stable until req_ready_i=1.
REQ-024 On the req_valid_o && req_ready_i handshake, SHALL subtract the burst beats from remaining and, for INCR only, advance the address by beats*BUS_BYTES.
REQ-025 After the handshake, SHALL go to DONE if remaining reaches 0, otherwise to CALC.
REQ-026 SHALL issue at most one request per CALC/ISSUE pair, giving a minimum spacing of 2 cycles between requests.
REQ-027 In DONE, SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-028 IDLE SHALL accept a new descriptor on the cycle immediately after DONE.
REQ-029 Abort: if str_valid_i=0 in CALC, or in ISSUE before the handshake, SHALL return to IDLE without handshaking and without asserting done_o.
REQ-030 A handshake occurring in the same cycle that str_valid_i falls SHALL complete; the block then returns to IDLE with no done_o pulse.
REQ-031 SHALL ignore changes to str_idx_i and the descriptor inputs outside IDLE.
REQ-032 SHALL drop unaligned low address bits (addr mod BUS_BYTES) from the 4 KB boundary calculation and SHALL emit the start address unmodified.
REQ-033 SHALL never generate an INCR burst that crosses a 4 KB boundary.

Reset
REQ-034 On rst=1 at a clock edge, SHALL enter IDLE, clear remaining, address and beats, and drive req_valid_o=0, done_o=0 and busy_o=0, including mid-burst.
REQ-035 SHALL not issue a request or pulse done_o on the first cycle after reset deasserts.

Verification
REQ-036 Bench SHALL cover: BUS_BYTES=8, addr 0x1000, bytes 64, INCR, ready tied to 1 -> one request (0x1000, len 7), then done_o one cycle later.
REQ-037 Bench SHALL cover: addr 0x0FF0, bytes 64 -> requests (0x0FF0, len 1) then (0x1000, len 5), then done_o.
REQ-038 Bench SHALL cover: bytes 4096 at 0x0, MAX_BEATS=256 -> two requests of len 255 (0x0, 0x800), then done_o.
REQ-039 Bench SHALL cover: FIXED mode, bytes 200 at 0x40 -> requests len 15 at 0x40 and len 8 at 0x40.
REQ-040 Bench SHALL cover: req_ready_i held 0 for 5 cycles -> req_* stable throughout; str_valid_i dropped in cycle 3 -> IDLE, no done_o.
REQ-041 Bench SHALL cover: bytes 0 -> done_o with no request; rst asserted mid-ISSUE -> all outputs 0 next cycle.
